// File: rtl/ulap_palette_loader_pkg.sv
// Shared constants and state type for the ULA+ palette loader.
package ulap_pkg;

  localparam logic [15:0] ULAP_REG = 16'hBF3B;
  localparam logic [15:0] ULAP_DAT = 16'hFF3B;

  localparam logic [1:0] GRP_PAL  = 2'b00;
  localparam logic [1:0] GRP_MODE = 2'b01;

  localparam logic [1:0] SEG_PAL = 2'd0;
  localparam logic [1:0] SEG_FIN = 2'd1;

  localparam logic [6:0] MAX_ENTRIES = 7'd64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_RECOV,
    ST_RELEASE
  } ld_state_t;

  function automatic logic [6:0] clamp_count(input logic [6:0] c);
    return (c > MAX_ENTRIES) ? MAX_ENTRIES : c;
  endfunction

endpackage

// File: rtl/ulap_palette_loader_io_write_seq.sv
// Z80-style I/O write timing: SETUP, IO_PULSE cycles of strobe low, IO_GAP recovery.
module io_write_seq
  import ulap_pkg::*;
#(
  parameter int unsigned IO_PULSE = 4,
  parameter int unsigned IO_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_go,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dout,
  output logic        o_nstb,
  output logic        o_idle,
  output logic        o_last
);

  localparam int unsigned CW = 8;

  ld_state_t     r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [15:0]   r_addr;
  logic [7:0]    r_dout;
  logic          r_nstb;
  logic          w_accept;

  assign o_idle   = (r_state == ST_IDLE);
  assign o_last   = (r_state == ST_RECOV) && (r_cnt == '0);
  // A new write may be chained onto the last recovery cycle with no idle gap.
  assign w_accept = i_go && (o_idle || o_last);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_n = ST_SETUP;
      ST_SETUP: begin
        w_state_n = ST_STROBE;
        w_cnt_n   = CW'(IO_PULSE - 1);
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state_n = ST_RECOV;
          w_cnt_n   = CW'(IO_GAP - 1);
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      ST_RECOV: begin
        if (r_cnt == '0) w_state_n = w_accept ? ST_SETUP : ST_IDLE;
        else             w_cnt_n   = r_cnt - 1'b1;
      end
      default:   w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_nstb  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_nstb  <= (w_state_n != ST_STROBE);
      if (w_accept) begin
        r_addr <= i_addr;
        r_dout <= i_data;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_dout = r_dout;
  assign o_nstb = r_nstb;

endmodule

// File: rtl/ulap_palette_loader.sv
// Bus initiator that replays ULA+ select/data port writes from a byte stream.
module ulap_palette_loader
  import ulap_pkg::*;
#(
  parameter int unsigned IO_PULSE = 4,
  parameter int unsigned IO_GAP   = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  start_idx,
  input  logic [6:0]  count,
  input  logic [7:0]  final_cfg,
  input  logic [5:0]  tmx_mode,
  input  logic        abort,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        nIORQ,
  output logic        nWR,
  output logic        busy,
  output logic        done,
  output logic        err
);

  ld_state_t   r_state, w_state_n;
  logic [5:0]  r_idx, w_idx_n;
  logic [6:0]  r_rem, w_rem_n;
  logic [1:0]  r_seg, w_seg_n;
  logic        r_phase, w_phase_n;
  logic        r_pend, w_pend_n;
  logic [7:0]  r_cfg;
  logic [5:0]  r_tmx;
  logic        r_bus_req, r_busy, r_done, r_err;
  logic        w_done_n, w_err_n;
  logic        w_go;
  logic [15:0] w_go_addr;
  logic [7:0]  w_go_data;
  logic        w_stop, w_last, w_seq_idle, w_nstb;

  assign w_stop  = abort || !bus_ack;
  assign s_ready = (r_state == ST_FETCH) && !w_stop;

  // ST_SETUP here spans a whole I/O cycle; the sequencer splits it into SETUP/STROBE/RECOV.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_rem_n   = r_rem;
    w_seg_n   = r_seg;
    w_phase_n = r_phase;
    w_pend_n  = r_pend;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_go      = 1'b0;
    w_go_addr = ULAP_REG;
    w_go_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n = ST_REQ;
          w_idx_n   = start_idx;
          w_rem_n   = clamp_count(count);
          w_seg_n   = (count == '0) ? SEG_FIN : SEG_PAL;
          w_phase_n = 1'b0;
          w_pend_n  = 1'b0;
        end
      end
      ST_REQ: begin
        if (abort) begin
          w_state_n = ST_RELEASE;
          w_err_n   = 1'b1;
        end else if (bus_ack && w_seq_idle) begin
          w_state_n = ST_SETUP;
          w_go      = 1'b1;
          w_go_data = (r_seg == SEG_PAL) ? {GRP_PAL, r_idx} : {GRP_MODE, r_tmx};
        end
      end
      ST_FETCH: begin
        if (w_stop) begin
          w_state_n = ST_RELEASE;
          w_err_n   = 1'b1;
        end else if (s_valid) begin
          w_state_n = ST_SETUP;
          w_go      = 1'b1;
          w_go_addr = ULAP_DAT;
          w_go_data = s_data;
        end
      end
      ST_SETUP: begin
        if (w_stop) w_pend_n = 1'b1;
        if (w_last) begin
          if (r_pend || w_stop) begin
            w_state_n = ST_RELEASE;
            w_err_n   = 1'b1;
          end else if (r_seg == SEG_PAL && !r_phase) begin
            w_state_n = ST_FETCH;
            w_phase_n = 1'b1;
          end else if (r_seg == SEG_PAL) begin
            w_phase_n = 1'b0;
            w_idx_n   = r_idx + 6'd1;
            w_rem_n   = r_rem - 7'd1;
            w_go      = 1'b1;
            if (r_rem == 7'd1) begin
              w_seg_n   = SEG_FIN;
              w_go_data = {GRP_MODE, r_tmx};
            end else begin
              w_go_data = {GRP_PAL, r_idx + 6'd1};
            end
          end else if (!r_phase) begin
            w_phase_n = 1'b1;
            w_go      = 1'b1;
            w_go_addr = ULAP_DAT;
            w_go_data = r_cfg;
          end else begin
            w_state_n = ST_RELEASE;
            w_done_n  = 1'b1;
          end
        end
      end
      ST_RELEASE: w_state_n = ST_IDLE;
      default:    w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rem     <= '0;
      r_seg     <= SEG_PAL;
      r_phase   <= 1'b0;
      r_pend    <= 1'b0;
      r_cfg     <= '0;
      r_tmx     <= '0;
      r_bus_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_rem     <= w_rem_n;
      r_seg     <= w_seg_n;
      r_phase   <= w_phase_n;
      r_pend    <= w_pend_n;
      r_bus_req <= (w_state_n == ST_REQ) || (w_state_n == ST_FETCH) || (w_state_n == ST_SETUP);
      r_busy    <= (w_state_n != ST_IDLE);
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      if (r_state == ST_IDLE && start) begin
        r_cfg <= final_cfg;
        r_tmx <= tmx_mode;
      end
    end
  end

  io_write_seq #(
    .IO_PULSE(IO_PULSE),
    .IO_GAP  (IO_GAP)
  ) u_seq (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .i_go   (w_go),
    .i_addr (w_go_addr),
    .i_data (w_go_data),
    .o_addr (addr),
    .o_dout (dout),
    .o_nstb (w_nstb),
    .o_idle (w_seq_idle),
    .o_last (w_last)
  );

  assign nIORQ   = w_nstb;
  assign nWR     = w_nstb;
  assign bus_req = r_bus_req;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_ulap_palette_loader.sv
// Randomised bench for ulap_palette_loader against a write-list and ULA+ register model.
module tb_ulap_palette_loader;

  localparam int unsigned IO_PULSE = 4;
  localparam int unsigned IO_GAP   = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  start_idx = '0;
  logic [6:0]  count = '0;
  logic [7:0]  final_cfg = '0;
  logic [5:0]  tmx_mode = '0;
  logic        abort = 1'b0;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        bus_req;
  logic        bus_ack;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        nIORQ, nWR, busy, done, err;

  always #5 clk_sys = ~clk_sys;

  ulap_palette_loader #(.IO_PULSE(IO_PULSE), .IO_GAP(IO_GAP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .start_idx(start_idx),
    .count(count), .final_cfg(final_cfg), .tmx_mode(tmx_mode), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .bus_req(bus_req),
    .bus_ack(bus_ack), .addr(addr), .dout(dout), .nIORQ(nIORQ), .nWR(nWR),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t        exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_pal[64];
  logic [7:0] pal[64];
  logic [7:0] ula_sel = '0;
  logic [7:0] ula_mode = '0;
  logic [7:0] fixed_b[2];

  int writes = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0, sready_cnt = 0;
  int hold_at = -1, hold_left = 0;
  bit hold_done = 0, gaps_en = 0, ack_tied = 1, mon_en = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Behavioural ULA+ decoder: select port picks group/index, data port writes it.
  task automatic ula_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'hBF3B) ula_sel = d;
    else if (a == 16'hFF3B) begin
      if (ula_sel[7:6] == 2'b00)      pal[ula_sel[5:0]] = d;
      else if (ula_sel[7:6] == 2'b01) ula_mode = d;
    end
  endtask

  // Bus monitor: every write against the expected list plus strobe/hold timing.
  logic        prev_n = 1'b1;
  logic [15:0] prev_a = '0;
  logic [7:0]  prev_d = '0;
  int          low_cnt = 0, post_cnt = 0;
  always @(negedge clk_sys) begin
    wr_t w;
    if (mon_en && reset_n) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      check("strobe_sync", nWR, nIORQ);
      if (!nIORQ) check("own_bus", bus_req & bus_ack, 1);
      if (prev_n && !nIORQ) begin
        check("pre_addr", addr, prev_a);
        check("pre_dout", dout, prev_d);
        writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_write: got %h<-%h, expected no write", addr, dout);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", addr, w.a);
          check("wr_data", dout, w.d);
        end
        ula_write(addr, dout);
        low_cnt = 1;
        post_cnt = 0;
      end else if (!prev_n && !nIORQ) begin
        low_cnt++;
        check("hold_addr", addr, prev_a);
        check("hold_dout", dout, prev_d);
      end else if (!prev_n && nIORQ) begin
        check("pulse_width", low_cnt, IO_PULSE);
        check("rise_addr", addr, prev_a);
        check("rise_dout", dout, prev_d);
        post_cnt = 1;
      end else if (post_cnt > 0) begin
        if (post_cnt < int'(IO_GAP)) begin
          check("gap_addr", addr, prev_a);
          check("gap_dout", dout, prev_d);
          post_cnt++;
        end else post_cnt = 0;
      end
      prev_n = nIORQ;
      prev_a = addr;
      prev_d = dout;
    end
  end

  // Byte source with optional random gaps and one long withhold at a given entry.
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk_sys);
      #1;
      if (hold_at >= 0 && !hold_done && hs_cnt == hold_at && s_ready) begin
        hold_left = 20;
        hold_done = 1;
      end
      if (hold_left > 0) begin
        hold_left--;
        s_valid = 1'b0;
        check("withhold_no_strobe", nIORQ, 1);
      end else if (src_q.size() > 0 && !(gaps_en && $urandom_range(0, 3) == 0)) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end
      #3;
      if (s_ready) sready_cnt++;
      if (s_valid && s_ready) begin
        void'(src_q.pop_front());
        hs_cnt++;
      end
    end
  end

  initial begin
    bus_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_tied)     bus_ack = 1'b1;
      else if (!bus_req) bus_ack = 1'b0;
      else if (!bus_ack && $urandom_range(0, 2) == 0) bus_ack = 1'b1;
    end
  end

  task automatic run(input int sidx, input int cnt, input logic [7:0] fcfg, input logic [5:0] tmx,
                     input bit fixed, input int abort_wr, input int expect_lat, input bit restart);
    int n, lat, exp_w;
    logic [7:0] b;
    bit aborting;
    n = (cnt > 64) ? 64 : cnt;
    aborting = (abort_wr >= 0);
    exp_q.delete();
    src_q.delete();
    hs_cnt = 0; sready_cnt = 0; writes = 0; done_cnt = 0; err_cnt = 0; hold_done = 0;
    for (int k = 0; k < n; k++) begin
      b = fixed ? fixed_b[k] : 8'($urandom);
      src_q.push_back(b);
      exp_q.push_back(mk(16'hBF3B, {2'b00, 6'((sidx + k) % 64)}));
      exp_q.push_back(mk(16'hFF3B, b));
      exp_pal[(sidx + k) % 64] = b;
    end
    exp_q.push_back(mk(16'hBF3B, {2'b01, tmx}));
    exp_q.push_back(mk(16'hFF3B, fcfg));
    exp_w = aborting ? abort_wr + 1 : 2 * n + 2;

    @(negedge clk_sys);
    check("idle_before_start", busy, 0);
    start = 1'b1; start_idx = 6'(sidx); count = 7'(cnt); final_cfg = fcfg; tmx_mode = tmx;
    lat = 0;
    forever begin
      @(negedge clk_sys);
      lat++;
      start = restart && lat == 40;
      start_idx = 6'($urandom); count = 7'($urandom); final_cfg = 8'($urandom); tmx_mode = 6'($urandom);
      if (lat == 1) begin
        check("start_to_busy", busy, 1);
        check("start_to_bus_req", bus_req, 1);
      end
      if (aborting && !abort && writes == abort_wr + 1 && !nIORQ) abort = 1'b1;
      if (done || err || lat > 3000) break;
    end
    start = 1'b0;
    if (lat > 3000) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no done/err after %0d cycles, expected completion", lat);
    end
    check("done_at_end", done, aborting ? 0 : 1);
    check("err_at_end", err, aborting ? 1 : 0);
    check("bus_req_released", bus_req, 0);
    if (expect_lat >= 0) check("latency", lat, expect_lat);
    abort = 1'b0;
    @(negedge clk_sys);
    check("busy_after", busy, 0);
    repeat (12) @(negedge clk_sys);
    check("write_count", writes, exp_w);
    check("exp_left", exp_q.size(), 2 * n + 2 - exp_w);
    check("done_pulses", done_cnt, aborting ? 0 : 1);
    check("err_pulses", err_cnt, aborting ? 1 : 0);
    check("handshakes", hs_cnt, aborting ? (abort_wr + 1) / 2 : n);
    if (cnt == 0) check("no_s_ready", sready_cnt, 0);
    if (!aborting) begin
      for (int k = 0; k < n; k++) check("palette", pal[(sidx + k) % 64], exp_pal[(sidx + k) % 64]);
      check("mode_reg", ula_mode, fcfg);
      check("sel_reg", ula_sel, {2'b01, tmx});
    end
  endtask

  initial begin
    fixed_b[0] = 8'hE0;
    fixed_b[1] = 8'h1C;
    repeat (2) @(negedge clk_sys);
    check("rst_bus_req", bus_req, 0);
    check("rst_nIORQ", nIORQ, 1);
    check("rst_nWR", nWR, 1);
    check("rst_addr", addr, 16'h0000);
    check("rst_dout", dout, 8'h00);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    run(0, 2, 8'h01, 6'd0, 1, -1, 46, 0);
    check("lit_pal0", pal[0], 8'hE0);
    check("lit_pal1", pal[1], 8'h1C);
    check("lit_ena", ula_mode[0], 1);
    check("lit_sel", ula_sel, 8'h40);

    run(62, 4, 8'h02, 6'd5, 0, -1, 4 * 15 + 16, 0);
    run(0, 0, 8'h03, 6'h2A, 0, -1, 16, 0);
    check("lit_cnt0_sel", ula_sel, 8'h6A);
    check("lit_cnt0_mode", ula_mode, 8'h03);

    hold_at = 3;
    run(10, 6, 8'h01, 6'd1, 0, -1, -1, 0);
    hold_at = -1;

    run(20, 10, 8'h01, 6'd0, 0, 11, -1, 0);
    run(5, 64, 8'h01, 6'd3, 0, -1, 64 * 15 + 16, 0);

    gaps_en = 1;
    ack_tied = 0;
    run(33, 100, 8'h02, 6'd7, 0, -1, -1, 1);
    for (int r = 0; r < 3; r++)
      run(int'($urandom_range(0, 63)), int'($urandom_range(0, 20)), 8'($urandom_range(0, 3)),
          6'($urandom), 0, -1, -1, 1);
    run(40, 8, 8'h01, 6'd0, 0, 5, -1, 0);

    // Async reset in the middle of a strobe must release the bus at once.
    gaps_en = 0;
    ack_tied = 1;
    mon_en = 0;
    src_q.delete();
    for (int k = 0; k < 3; k++) src_q.push_back(8'($urandom));
    @(negedge clk_sys);
    start = 1'b1; start_idx = 6'd0; count = 7'd3;
    @(negedge clk_sys);
    start = 1'b0;
    for (int t = 0; t < 200 && nIORQ; t++) @(negedge clk_sys);
    check("pre_reset_strobe_low", nIORQ, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_nIORQ", nIORQ, 1);
    check("async_rst_nWR", nWR, 1);
    check("async_rst_bus_req", bus_req, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
